// File: rtl/raifes_dm_hart_ctrl.sv
// ---------------------------------------------------------------------------
// raifes_dm_hart_ctrl
// Debug Module hart-control stage. It sits directly upstream of the debug ROM
// status word. It turns the dmcontrol haltreq/resumereq levels and
// abstract-command writes into three things: the core halt request, and the
// two ROM handshakes (resume_req level and postexec_req pulse). It follows
// program-buffer execution until the ROM is re-entered, an exception is
// taken, or the timeout expires. It reports busy, cmderr and the dmstatus
// all* flags back to the DMI registers.
//
// Parameters
//   PROG_TIMEOUT    max cycles a postexec may spend in EXEC_WAIT + EXEC_RUN
//   CNT_W           timeout counter width (PROG_TIMEOUT < 2**CNT_W)
//
// Ports
//   clk             system clock
//   nreset          asynchronous active-low reset
//   haltreq         dmcontrol.haltreq level
//   resumereq       dmcontrol.resumereq level (acted on at its rising edge)
//   cmd_valid       one-cycle pulse: abstract command written
//   cmd_postexec    postexec bit of that command
//   cmderr_clr      one-cycle pulse: W1C of abstractcs.cmderr
//   rom_halted      ROM status[1], hart parked in the debug ROM
//   rom_resume_ack  ROM status[0], hart acknowledged the resume
//   rom_postexec    ROM status[2], postexec pending in the ROM
//   rom_entry       pulse: core fetched debug-ROM word 0
//   hart_exc        pulse: exception taken while in debug mode
//   dbg_haltreq     halt request to the core
//   resume_req      resume request level to the ROM
//   postexec_req    one-cycle pulse to the ROM, sets ROM status[2]
//   cmd_busy        abstractcs.busy
//   cmderr          abstractcs.cmderr (sticky, first error wins)
//   allhalted       dmstatus.allhalted
//   allrunning      dmstatus.allrunning
//   allresumeack    dmstatus.allresumeack (sticky)
// ---------------------------------------------------------------------------
module raifes_dm_hart_ctrl #(
   parameter int PROG_TIMEOUT = 1023,
   parameter int CNT_W        = 10
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       haltreq,
   input  logic       resumereq,
   input  logic       cmd_valid,
   input  logic       cmd_postexec,
   input  logic       cmderr_clr,
   input  logic       rom_halted,
   input  logic       rom_resume_ack,
   input  logic       rom_postexec,
   input  logic       rom_entry,
   input  logic       hart_exc,
   output logic       dbg_haltreq,
   output logic       resume_req,
   output logic       postexec_req,
   output logic       cmd_busy,
   output logic [2:0] cmderr,
   output logic       allhalted,
   output logic       allrunning,
   output logic       allresumeack
);

   typedef enum logic [2:0] {
      RUNNING,
      HALTING,
      HALTED,
      EXEC_WAIT,
      EXEC_RUN,
      RESUMING
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] counter;
   logic             seen;
   logic             resumereq_q;
   logic             in_exec;
   logic             resume_rise;
   logic             timeout;
   logic [2:0]       new_err;

   // Decode the current state and inputs into the events the FSM and the
   // error register react to. Timeout fires on the edge where the counter
   // would reach PROG_TIMEOUT. A postexec therefore gets exactly
   // PROG_TIMEOUT cycles of busy before it is aborted. An exception or a
   // timeout outranks a command that collides with it. A command arriving
   // while the program buffer runs is reported as busy (1). A command in
   // any non-halted state is reported as halt/resume (4).
   always_comb begin
      in_exec     = (state == EXEC_WAIT) || (state == EXEC_RUN);
      resume_rise = resumereq & ~resumereq_q;
      timeout     = in_exec && (counter == CNT_W'(PROG_TIMEOUT - 1));
      new_err     = 3'd0;
      if (in_exec && (hart_exc || timeout)) begin
         new_err = 3'd3;
      end else if (cmd_valid && in_exec) begin
         new_err = 3'd1;
      end else if (cmd_valid && (state != HALTED)) begin
         new_err = 3'd4;
      end
   end

   // cmderr is sticky and keeps only the first error. A clear pulse zeroes
   // it. If a new error lands in the same cycle as the clear, the new error
   // is stored, so the clear can never hide a fresh failure.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cmderr <= 3'd0;
      end else if ((new_err != 3'd0) && ((cmderr == 3'd0) || cmderr_clr)) begin
         cmderr <= new_err;
      end else if (cmderr_clr) begin
         cmderr <= 3'd0;
      end
   end

   // Main hart-control FSM. Every output is registered here and updated on
   // the same edge as the state change that implies it. The host therefore
   // never sees the state and the status flags disagree. postexec_req
   // defaults low, so it pulses for exactly the one cycle after a postexec
   // command is accepted. Reset drops straight back to RUNNING without a
   // pulse. A haltreq seen while resuming is simply not looked at until
   // RUNNING, which is what defers it.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state        <= RUNNING;
         counter      <= '0;
         seen         <= 1'b0;
         resumereq_q  <= 1'b0;
         dbg_haltreq  <= 1'b0;
         resume_req   <= 1'b0;
         postexec_req <= 1'b0;
         cmd_busy     <= 1'b0;
         allhalted    <= 1'b0;
         allrunning   <= 1'b1;
         allresumeack <= 1'b0;
      end else begin
         resumereq_q  <= resumereq;
         postexec_req <= 1'b0;
         case (state)
            RUNNING: begin
               if (haltreq) begin
                  state       <= HALTING;
                  dbg_haltreq <= 1'b1;
               end else if (resume_rise) begin
                  allresumeack <= 1'b1;
               end
            end
            HALTING: begin
               if (rom_halted) begin
                  state       <= HALTED;
                  dbg_haltreq <= 1'b0;
                  allhalted   <= 1'b1;
                  allrunning  <= 1'b0;
               end
            end
            HALTED: begin
               if (!rom_halted) begin
                  state      <= RUNNING;
                  allhalted  <= 1'b0;
                  allrunning <= 1'b1;
               end else if (resume_rise && !haltreq) begin
                  state        <= RESUMING;
                  resume_req   <= 1'b1;
                  allresumeack <= 1'b0;
               end else if (cmd_valid && cmd_postexec && (cmderr == 3'd0)) begin
                  state        <= EXEC_WAIT;
                  cmd_busy     <= 1'b1;
                  postexec_req <= 1'b1;
                  counter      <= '0;
                  seen         <= 1'b0;
               end
            end
            EXEC_WAIT, EXEC_RUN: begin
               counter <= counter + 1'b1;
               if (hart_exc || timeout) begin
                  state    <= HALTED;
                  cmd_busy <= 1'b0;
               end else if (state == EXEC_WAIT) begin
                  if (rom_postexec) begin
                     seen <= 1'b1;
                  end else if (seen) begin
                     state <= EXEC_RUN;
                  end
               end else if (rom_entry) begin
                  state    <= HALTED;
                  cmd_busy <= 1'b0;
               end
            end
            RESUMING: begin
               if (rom_resume_ack) begin
                  state        <= RUNNING;
                  resume_req   <= 1'b0;
                  allresumeack <= 1'b1;
                  allhalted    <= 1'b0;
                  allrunning   <= 1'b1;
               end
            end
            default: begin
               state <= RUNNING;
            end
         endcase
      end
   end

endmodule
